cfg_cmd_master: RTL and testbench
=================================

Name: cfg_cmd_master

Overview:
Host-side initiator for the TPU configuration register file. Parses a byte-stream command protocol (valid/ready, e.g. from a UART receiver) into single-cycle register write pulses and combinational register reads, and returns ACK/NAK or read data on an outgoing byte stream. Sits between the host link and the config register file's write/read ports.

Parameters:
TIMEOUT_CYCLES, 1000000, inter-byte idle cycles before a partial command is aborted (used only with CFG_CMD_TIMEOUT_EN)
ACK_BYTE, 8'h06, response byte for a completed write
NAK_BYTE, 8'h15, response byte for an unknown opcode or an aborted command

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  host command byte valid
in_ready  output  1  block accepts command byte
in_data  input  8  host command byte
out_valid  output  1  response byte valid
out_ready  input  1  host link accepts response byte
out_data  output  8  response byte
wr_en  output  1  register write strobe, one cycle
reg_addr  output  8  write address
reg_data  output  32  write data
rd_addr  output  8  read address
rd_data  input  32  combinational read data for rd_addr
busy  output  1  command in progress (state != IDLE)
cmd_error  output  1  one-cycle pulse on NAK generation

Behaviour:
- One clock (clk); reset is asynchronous and active-high.
- Byte transfers on valid&&ready. out_data/out_valid are held stable until out_ready.
- Protocol: 0x57 'W', addr, d0, d1, d2, d3 (little-endian) -> write, respond ACK_BYTE. 0x52 'R', addr -> read, respond 4 bytes rd_data little-endian. Any other opcode -> NAK_BYTE; opcode byte consumed.
- FSM states: IDLE, GET_ADDR, GET_DATA (2-bit byte counter 0..3), DO_WRITE, DO_READ, SEND (2-bit byte counter, 1 or 4 bytes).
- in_ready = 1 only in IDLE/GET_ADDR/GET_DATA; 0 in all other states and while reset is high.
- IDLE: opcode W -> GET_ADDR(write); R -> GET_ADDR(read); other -> SEND with NAK, cmd_error pulse.
- GET_ADDR: latch addr; write -> GET_DATA, read -> DO_READ.
- GET_DATA: shift byte into reg_data[8*k+:8]; after k=3 -> DO_WRITE.
- Write latency: last data byte accepted in cycle N -> wr_en=1 in cycle N+1 only, reg_addr/reg_data valid then; ACK out_valid from N+2.
- Read latency: addr accepted in cycle N -> rd_addr=addr from N+1; rd_data sampled at end of N+1 (DO_READ); out_valid with byte0 from N+2.
- SEND: returns to IDLE after final byte handshake. New opcode accepted the cycle after.
- reg_addr, reg_data and rd_addr hold their last values between commands.
- Reset values: wr_en 0, reg_addr 0, reg_data 0, rd_addr 0, out_valid 0, out_data 0, busy 0, cmd_error 0, state IDLE, counters 0.
- Reset mid-command: partial command discarded, no wr_en, pending response dropped.
- wr_en is never asserted except in DO_WRITE.

Optional Feature:
CFG_CMD_TIMEOUT_EN: defined -> a counter clears on every accepted byte and increments in GET_ADDR/GET_DATA; on reaching TIMEOUT_CYCLES, the FSM aborts to SEND with NAK_BYTE and pulses cmd_error, with no wr_en. Undefined -> no counter; a partial command waits indefinitely.

Decomposition:
- Package cfg_cmd_pkg: opcode constants (OP_WRITE 8'h57, OP_READ 8'h52), default ACK/NAK bytes, FSM state enum.
- No sub-module; single module. Timeout counter is inline under the macro.

Test Plan:
- Send 57 00 05 00 00 00 -> one wr_en pulse with reg_addr=00, reg_data=32'h00000005; out byte 06; busy then drops.
- Send 52 01 with model rd_data=32'hA1B2C3D4 at addr 01 -> rd_addr=01; out bytes D4 C3 B2 A1 in order.
- Send AA -> out byte 15, one cmd_error pulse, no wr_en; a following valid write then completes normally.
- Run the read test with out_ready held low 10 cycles per byte -> out_data stable while stalled, in_ready=0, no byte lost or duplicated.
- Assert reset after 57 03 11 22 -> no wr_en, all outputs at reset values; a subsequent full write to 03 succeeds.
- With CFG_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 57 03, then idle 16 cycles -> NAK 15, cmd_error pulse, no wr_en, return to IDLE.

Source files
------------

// File: rtl/cfg_cmd_pkg.sv
// Shared constants and FSM state type for the host-side config command master.
package cfg_cmd_pkg;

  localparam logic [7:0] OP_WRITE     = 8'h57;
  localparam logic [7:0] OP_READ      = 8'h52;
  localparam logic [7:0] DEF_ACK_BYTE = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StDoWrite,
    StDoRead,
    StSend
  } state_e;

endpackage

// File: rtl/cfg_cmd_master.sv
// Byte-stream command parser driving config register write/read ports.
// Optional inter-byte abort timer enabled by defining CFG_CMD_TIMEOUT_EN.
module cfg_cmd_master
  import cfg_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE       = DEF_NAK_BYTE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        wr_en,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_data,
  output logic [7:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic        cmd_error
);

  state_e      state_q, state_d;
  logic        is_read_q;
  logic [1:0]  cnt_q;
  logic [1:0]  last_q;
  logic [31:0] resp_q;
  logic [7:0]  reg_addr_q;
  logic [31:0] reg_data_q;
  logic [7:0]  rd_addr_q;
  logic        cmd_error_q;

  logic in_fire, out_fire, bad_op, timeout, nak_evt;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign bad_op   = (in_data != OP_WRITE) && (in_data != OP_READ);
  assign nak_evt  = ((state_q == StIdle) && in_fire && bad_op) || timeout;

`ifdef CFG_CMD_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;
  logic            tmo_active;

  assign tmo_active = (state_q == StGetAddr) || (state_q == StGetData);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (in_fire || !tmo_active) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Abort on the cycle the count would reach TIMEOUT_CYCLES.
  assign timeout = tmo_active && !in_fire && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_fire) state_d = bad_op ? StSend : StGetAddr;
      end
      StGetAddr: begin
        if (in_fire)      state_d = is_read_q ? StDoRead : StGetData;
        else if (timeout) state_d = StSend;
      end
      StGetData: begin
        if (in_fire && (cnt_q == 2'd3)) state_d = StDoWrite;
        else if (timeout)               state_d = StSend;
      end
      StDoWrite: state_d = StSend;
      StDoRead:  state_d = StSend;
      StSend: begin
        if (out_fire && (cnt_q == last_q)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle, StGetAddr, StGetData: in_ready = !reset;
      StDoWrite:                    wr_en = 1'b1;
      StSend:                       out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data  = resp_q[7:0];
  assign reg_addr  = reg_addr_q;
  assign reg_data  = reg_data_q;
  assign rd_addr   = rd_addr_q;
  assign cmd_error = cmd_error_q;

  // Datapath: address/data capture and response shift buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_read_q   <= 1'b0;
      cnt_q       <= '0;
      last_q      <= '0;
      resp_q      <= '0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      rd_addr_q   <= '0;
      cmd_error_q <= 1'b0;
    end else begin
      cmd_error_q <= nak_evt;
      unique case (state_q)
        StIdle: begin
          if (in_fire) begin
            is_read_q <= (in_data == OP_READ);
            cnt_q     <= '0;
            if (bad_op) begin
              resp_q <= {24'h0, NAK_BYTE};
              last_q <= '0;
            end
          end
        end
        StGetAddr: begin
          if (in_fire) begin
            if (is_read_q) rd_addr_q  <= in_data;
            else           reg_addr_q <= in_data;
            cnt_q <= '0;
          end else if (timeout) begin
            resp_q <= {24'h0, NAK_BYTE};
            last_q <= '0;
            cnt_q  <= '0;
          end
        end
        StGetData: begin
          if (in_fire) begin
            reg_data_q[{cnt_q, 3'b000} +: 8] <= in_data;
            cnt_q <= cnt_q + 2'd1;
          end else if (timeout) begin
            resp_q <= {24'h0, NAK_BYTE};
            last_q <= '0;
            cnt_q  <= '0;
          end
        end
        StDoWrite: begin
          resp_q <= {24'h0, ACK_BYTE};
          last_q <= '0;
          cnt_q  <= '0;
        end
        StDoRead: begin
          resp_q <= rd_data;
          last_q <= 2'd3;
          cnt_q  <= '0;
        end
        StSend: begin
          if (out_fire) begin
            resp_q <= {8'h00, resp_q[31:8]};
            cnt_q  <= cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_cmd_master.sv
// Directed bench for cfg_cmd_master: vector table plus latency, stall, reset and timeout sequences.
module tb_cfg_cmd_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        wr_en;
  logic [7:0]  reg_addr;
  logic [31:0] reg_data;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        cmd_error;

  int n_pass  = 0;
  int n_total = 0;
  int wr_cnt  = 0;
  int err_cnt = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  cfg_cmd_master #(
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .wr_en     (wr_en),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .cmd_error (cmd_error)
  );

  // Register file model
  always @(posedge clk) begin
    if (reset) mem[1] <= 32'hA1B2C3D4;
    else if (wr_en) mem[reg_addr] <= reg_data;
  end
  assign rd_data = mem[rd_addr];

  always @(negedge clk) begin
    if (wr_en)     wr_cnt  <= wr_cnt + 1;
    if (cmd_error) err_cnt <= err_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached, expected self-termination");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("send_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(input int stall, output logic [7:0] b);
    int n = 0;
    bit ok = 1'b1;
    logic [7:0] first;
    out_ready = 1'b0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      check("resp_wait", 32'(out_valid), 32'd1);
      b = 8'h00;
      return;
    end
    first = out_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (out_data !== first || !out_valid || in_ready) ok = 1'b0;
    end
    if (stall > 0) check("stall_hold", 32'(ok), 32'd1);
    b = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    int          nb;
    logic [47:0] cmd;
    int          nr;
    logic [31:0] resp;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0]  b;
    logic [31:0] exp_rd;
    int w0, e0;

    vecs[0] = '{6, 48'h000000050057, 1, 32'h00000006, 1'b1, 8'h00, 32'h00000005, 1'b0};
    vecs[1] = '{2, 48'h000000000152, 4, 32'hA1B2C3D4, 1'b0, 8'h01, 32'h0, 1'b0};
    vecs[2] = '{1, 48'h0000000000AA, 1, 32'h00000015, 1'b0, 8'h00, 32'h0, 1'b1};
    vecs[3] = '{6, 48'h123456781057, 1, 32'h00000006, 1'b1, 8'h10, 32'h12345678, 1'b0};
    vecs[4] = '{2, 48'h000000001052, 4, 32'h12345678, 1'b0, 8'h10, 32'h0, 1'b0};
    vecs[5] = '{1, 48'h000000000077, 1, 32'h00000015, 1'b0, 8'h00, 32'h0, 1'b1};
    vecs[6] = '{6, 48'hEFBEADDEFF57, 1, 32'h00000006, 1'b1, 8'hFF, 32'hEFBEADDE, 1'b0};
    vecs[7] = '{2, 48'h00000000FF52, 4, 32'hEFBEADDE, 1'b0, 8'hFF, 32'h0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_data", reg_data, 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_error", 32'(cmd_error), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      w0 = wr_cnt;
      e0 = err_cnt;
      for (int j = 0; j < vecs[i].nb; j++) send_byte(vecs[i].cmd[8*j +: 8]);
      for (int j = 0; j < vecs[i].nr; j++) begin
        recv_byte(0, b);
        check($sformatf("v%0d_resp%0d", i, j), 32'(b), 32'(vecs[i].resp[8*j +: 8]));
      end
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_wr_cnt", i), wr_cnt - w0, 32'(vecs[i].wr));
      check($sformatf("v%0d_err_cnt", i), err_cnt - e0, 32'(vecs[i].err));
      if (vecs[i].wr) begin
        check($sformatf("v%0d_reg_addr", i), 32'(reg_addr), 32'(vecs[i].addr));
        check($sformatf("v%0d_reg_data", i), reg_data, vecs[i].data);
      end else if (vecs[i].nr == 4) begin
        check($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(vecs[i].addr));
      end
    end

    // Write latency: wr_en exactly one cycle after the last data byte, ACK the cycle after
    send_byte(8'h57);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    check("wl_ready_last", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h04;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("wl_wr_en_n1", 32'(wr_en), 32'd1);
    check("wl_reg_addr", 32'(reg_addr), 32'h04);
    check("wl_reg_data", reg_data, 32'h04030201);
    check("wl_out_valid_n1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("wl_wr_en_n2", 32'(wr_en), 32'd0);
    check("wl_out_valid_n2", 32'(out_valid), 32'd1);
    check("wl_ack", 32'(out_data), 32'h06);
    recv_byte(0, b);
    check("wl_busy_end", 32'(busy), 32'd0);

    // Read latency, then each response byte stalled for 10 cycles
    exp_rd = 32'hA1B2C3D4;
    send_byte(8'h52);
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rl_rd_addr", 32'(rd_addr), 32'h01);
    check("rl_out_valid_n1", 32'(out_valid), 32'd0);
    check("rl_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("rl_out_valid_n2", 32'(out_valid), 32'd1);
    check("rl_byte0_early", 32'(out_data), 32'hD4);
    for (int j = 0; j < 4; j++) begin
      recv_byte(10, b);
      check($sformatf("stall_byte%0d", j), 32'(b), 32'(exp_rd[8*j +: 8]));
    end
    check("stall_busy_end", 32'(busy), 32'd0);

    // Reset in the middle of a write
    w0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    #1;
    check("mr_in_ready", 32'(in_ready), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_reg_addr", 32'(reg_addr), 32'd0);
    check("mr_reg_data", reg_data, 32'd0);
    check("mr_rd_addr", 32'(rd_addr), 32'd0);
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("mr_no_wr", wr_cnt - w0, 32'd0);
    send_byte(8'h57);
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    recv_byte(0, b);
    check("mr_after_ack", 32'(b), 32'h06);
    check("mr_after_wr", wr_cnt - w0, 32'd1);
    check("mr_after_addr", 32'(reg_addr), 32'h03);
    check("mr_after_data", reg_data, 32'hDDCCBBAA);

`ifdef CFG_CMD_TIMEOUT_EN
    // Partial command aborted after 16 idle cycles
    w0 = wr_cnt;
    e0 = err_cnt;
    send_byte(8'h57);
    send_byte(8'h03);
    repeat (10) @(posedge clk);
    #1;
    check("to_busy_early", 32'(busy), 32'd1);
    check("to_no_resp_early", 32'(out_valid), 32'd0);
    recv_byte(0, b);
    check("to_nak", 32'(b), 32'h15);
    check("to_err", err_cnt - e0, 32'd1);
    check("to_no_wr", wr_cnt - w0, 32'd0);
    check("to_idle", 32'(busy), 32'd0);
    check("to_ready", 32'(in_ready), 32'd1);
`else
    // Partial command waits indefinitely, then completes
    w0 = wr_cnt;
    e0 = err_cnt;
    send_byte(8'h57);
    send_byte(8'h03);
    repeat (40) @(posedge clk);
    #1;
    check("nt_busy", 32'(busy), 32'd1);
    check("nt_no_resp", 32'(out_valid), 32'd0);
    check("nt_ready", 32'(in_ready), 32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    recv_byte(0, b);
    check("nt_ack", 32'(b), 32'h06);
    check("nt_wr", wr_cnt - w0, 32'd1);
    check("nt_err", err_cnt - e0, 32'd0);
    check("nt_data", reg_data, 32'h04030201);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
